// File: rtl/zsram_pkg.sv
// Shared ZSRAM definitions: array geometry defaults, reader state encoding
// and controller counter width. Imported by both the reader and the writer.
package zsram_pkg;

  localparam int ZS_WIDTH = 8;
  localparam int ZS_DEPTH = 16;
  localparam int ZS_AW    = 4;

  // Strobe/settle counters; legal cycle counts (<= 15) always fit.
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    STROBE = 3'd2,
    SETTLE = 3'd3,
    RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/zsram_row_decode.sv
// AW-to-DEPTH one-hot row decoder. Output is all-zero when disabled or when
// the address does not name an existing row.
module zsram_row_decode
  import zsram_pkg::*;
#(
  parameter int AW    = ZS_AW,
  parameter int DEPTH = ZS_DEPTH
) (
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  output logic [DEPTH-1:0] onehot_o
);

  // One compare per row; addresses >= DEPTH match nothing.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (en_i && (addr_i == AW'(i))) begin
        onehot_o[i] = 1'b1;
      end else begin
        onehot_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/zsram_row_reader.sv
// ZSRAM read-side controller: strobes one row's ReadEdge, waits for the cells
// to settle, captures the word and returns it on a valid/ready channel.
module zsram_row_reader
  import zsram_pkg::*;
#(
  parameter int WIDTH      = ZS_WIDTH,
  parameter int DEPTH      = ZS_DEPTH,
  parameter int AW         = ZS_AW,
  parameter int STROBE_CYC = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic             Crystal50Mhz1,
  input  logic             ResetLow,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [AW-1:0]    ReqAddr,
  output logic [DEPTH-1:0] ReadEdge,
  input  logic [WIDTH-1:0] outputData,
  input  logic             WriteBusy,
  input  logic [AW-1:0]    WriteRow,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspData,
  output logic [AW-1:0]    RspAddr,
  output logic             RspError,
  output logic             Busy
);

  localparam logic [AW:0]      DEPTH_W     = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    addr_q;

  logic [AW-1:0]    cand_addr_s;
  logic             conflict_s;
  logic             oor_s;
  logic [DEPTH-1:0] row_sel_s;

  // In IDLE the candidate row is the incoming request, otherwise the latched one.
  assign cand_addr_s = (state_q == IDLE) ? ReqAddr : addr_q;
  assign conflict_s  = WriteBusy && (WriteRow == cand_addr_s);
  assign oor_s       = ({1'b0, ReqAddr} >= DEPTH_W);
  assign RspAddr     = addr_q;

  zsram_row_decode #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_decode (
    .en_i     (1'b1),
    .addr_i   (cand_addr_s),
    .onehot_o (row_sel_s)
  );

  // Read FSM; every output is loaded here so all outputs are registered.
  always_ff @(posedge Crystal50Mhz1 or negedge ResetLow) begin
    if (!ResetLow) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      ReqReady <= 1'b0;
      ReadEdge <= '0;
      RspValid <= 1'b0;
      RspData  <= '0;
      RspError <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ReqValid && ReqReady) begin
            addr_q   <= ReqAddr;
            cnt_q    <= '0;
            ReqReady <= 1'b0;
            Busy     <= 1'b1;
            if (oor_s) begin
              state_q  <= RESP;
              RspData  <= '0;
              RspError <= 1'b1;
              RspValid <= 1'b1;
            end else if (conflict_s) begin
              state_q  <= WAIT;
              RspError <= 1'b0;
            end else begin
              state_q  <= STROBE;
              RspError <= 1'b0;
              ReadEdge <= row_sel_s;
            end
          end else begin
            ReqReady <= 1'b1;
          end
        end
        WAIT: begin
          if (!conflict_s) begin
            state_q  <= STROBE;
            cnt_q    <= '0;
            ReadEdge <= row_sel_s;
          end else begin
            ReadEdge <= '0;
          end
        end
        STROBE: begin
          // A write to our row aborts the strobe; it restarts in full later.
          if (conflict_s) begin
            state_q  <= WAIT;
            cnt_q    <= '0;
            ReadEdge <= '0;
          end else if (cnt_q == STROBE_LAST) begin
            cnt_q    <= '0;
            ReadEdge <= '0;
            if (SETTLE_CYC == 0) begin
              state_q  <= RESP;
              RspData  <= outputData;
              RspValid <= 1'b1;
            end else begin
              state_q <= SETTLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q  <= RESP;
            cnt_q    <= '0;
            RspData  <= outputData;
            RspValid <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (RspReady) begin
            state_q  <= IDLE;
            RspValid <= 1'b0;
            Busy     <= 1'b0;
            ReqReady <= 1'b1;
          end else begin
            RspValid <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          ReadEdge <= '0;
          RspValid <= 1'b0;
          Busy     <= 1'b0;
          ReqReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zsram_row_reader.sv
// Directed bench for zsram_row_reader (DEPTH=12 so out-of-range rows exist,
// default strobe/settle timing).
module tb_zsram_row_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 12;
  localparam int AW    = 4;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_addr;
  logic [DEPTH-1:0] read_edge;
  logic [WIDTH-1:0] out_data;
  logic             write_busy;
  logic [AW-1:0]    write_row;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [AW-1:0]    rsp_addr;
  logic             rsp_error;
  logic             busy;

  int nvec;
  int nerr;

  zsram_row_reader #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .STROBE_CYC (2),
    .SETTLE_CYC (1)
  ) dut (
    .Crystal50Mhz1 (clk),
    .ResetLow      (rst_n),
    .ReqValid      (req_valid),
    .ReqReady      (req_ready),
    .ReqAddr       (req_addr),
    .ReadEdge      (read_edge),
    .outputData    (out_data),
    .WriteBusy     (write_busy),
    .WriteRow      (write_row),
    .RspValid      (rsp_valid),
    .RspReady      (rsp_ready),
    .RspData       (rsp_data),
    .RspAddr       (rsp_addr),
    .RspError      (rsp_error),
    .Busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    nvec       = 0;
    nerr       = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 4'd0;
    out_data   = 8'h00;
    write_busy = 1'b0;
    write_row  = 4'd0;
    rsp_ready  = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_edge",  32'(read_edge), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    chk("rst_data",  32'(rsp_data),  32'h0);
    chk("rst_addr",  32'(rsp_addr),  32'h0);
    chk("rst_err",   32'(rsp_error), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(req_ready), 32'h1);

    // Basic read of row 3 (cycle T = now)
    req_valid = 1'b1; req_addr = 4'd3; out_data = 8'hA5;
    tick();
    req_valid = 1'b0;
    chk("b_edge1",  32'(read_edge), 32'h008);
    chk("b_busy",   32'(busy),      32'h1);
    chk("b_ready",  32'(req_ready), 32'h0);
    tick();
    chk("b_edge2",  32'(read_edge), 32'h008);
    tick();
    chk("b_edge3",  32'(read_edge), 32'h000);
    chk("b_nvalid", 32'(rsp_valid), 32'h0);
    tick();
    chk("b_valid",  32'(rsp_valid), 32'h1);
    chk("b_data",   32'(rsp_data),  32'hA5);
    chk("b_addr",   32'(rsp_addr),  32'h3);
    chk("b_err",    32'(rsp_error), 32'h0);
    tick();
    chk("b_done_v", 32'(rsp_valid), 32'h0);
    chk("b_done_r", 32'(req_ready), 32'h1);

    // Out of range row 13
    req_valid = 1'b1; req_addr = 4'd13;
    tick();
    req_valid = 1'b0;
    chk("o_valid",  32'(rsp_valid), 32'h1);
    chk("o_data",   32'(rsp_data),  32'h0);
    chk("o_err",    32'(rsp_error), 32'h1);
    chk("o_addr",   32'(rsp_addr),  32'hD);
    chk("o_edge",   32'(read_edge), 32'h0);
    tick();
    chk("o_done_v", 32'(rsp_valid), 32'h0);
    chk("o_edge2",  32'(read_edge), 32'h0);
    chk("o_done_r", 32'(req_ready), 32'h1);

    // Write conflict at accept on row 5, cleared at T+4
    req_valid = 1'b1; req_addr = 4'd5; write_busy = 1'b1; write_row = 4'd5; out_data = 8'h5A;
    for (int i = 1; i <= 4; i++) begin
      tick();
      req_valid = 1'b0;
      if (i == 4) write_busy = 1'b0;
      chk("w_hold", 32'(read_edge), 32'h0);
    end
    tick();
    chk("w_edge5", 32'(read_edge), 32'h020);
    tick();
    chk("w_edge6", 32'(read_edge), 32'h020);
    tick();
    chk("w_edge7", 32'(read_edge), 32'h000);
    chk("w_nval7", 32'(rsp_valid), 32'h0);
    tick();
    chk("w_valid", 32'(rsp_valid), 32'h1);
    chk("w_data",  32'(rsp_data),  32'h5A);
    chk("w_addr",  32'(rsp_addr),  32'h5);
    tick();

    // Conflict mid-strobe on row 2 at T+1 only
    req_valid = 1'b1; req_addr = 4'd2; out_data = 8'h3C;
    tick();
    req_valid = 1'b0; write_busy = 1'b1; write_row = 4'd2;
    chk("m_edge1", 32'(read_edge), 32'h004);
    tick();
    write_busy = 1'b0;
    chk("m_edge2", 32'(read_edge), 32'h000);
    tick();
    chk("m_edge3", 32'(read_edge), 32'h004);
    tick();
    chk("m_edge4", 32'(read_edge), 32'h004);
    tick();
    chk("m_edge5", 32'(read_edge), 32'h000);
    chk("m_nval5", 32'(rsp_valid), 32'h0);
    tick();
    chk("m_valid", 32'(rsp_valid), 32'h1);
    chk("m_data",  32'(rsp_data),  32'h3C);
    tick();

    // Response backpressure: row 7 captured, stall 5 cycles with a request pending
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 4'd7; out_data = 8'hC3;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    req_valid = 1'b1; req_addr = 4'd1;
    for (int i = 0; i < 5; i++) begin
      chk("s_valid", 32'(rsp_valid), 32'h1);
      chk("s_data",  32'(rsp_data),  32'hC3);
      chk("s_ready", 32'(req_ready), 32'h0);
      out_data = 8'h10 + 8'(i);
      tick();
    end
    rsp_ready = 1'b1; out_data = 8'h99;
    chk("s_valid9", 32'(rsp_valid), 32'h1);
    chk("s_data9",  32'(rsp_data),  32'hC3);
    tick();
    chk("s_rdy10",  32'(req_ready), 32'h1);
    chk("s_nval10", 32'(rsp_valid), 32'h0);
    tick();
    req_valid = 1'b0;
    chk("s_edge11", 32'(read_edge), 32'h002);
    tick();
    chk("s_edge12", 32'(read_edge), 32'h002);
    tick();
    tick();
    chk("s_valid2", 32'(rsp_valid), 32'h1);
    chk("s_data2",  32'(rsp_data),  32'h99);
    chk("s_addr2",  32'(rsp_addr),  32'h1);
    tick();

    // Reset during STROBE of row 4
    req_valid = 1'b1; req_addr = 4'd4; out_data = 8'h77;
    tick();
    req_valid = 1'b0;
    chk("r_edge1", 32'(read_edge), 32'h010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_async_edge",  32'(read_edge), 32'h0);
    chk("r_async_valid", 32'(rsp_valid), 32'h0);
    chk("r_async_busy",  32'(busy),      32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("r_rel_ready", 32'(req_ready), 32'h1);
    chk("r_rel_valid", 32'(rsp_valid), 32'h0);
    req_valid = 1'b1; req_addr = 4'd0; out_data = 8'h66;
    tick();
    req_valid = 1'b0;
    chk("r_edge_a", 32'(read_edge), 32'h001);
    tick();
    chk("r_edge_b", 32'(read_edge), 32'h001);
    tick();
    chk("r_nval", 32'(rsp_valid), 32'h0);
    tick();
    chk("r_valid", 32'(rsp_valid), 32'h1);
    chk("r_data",  32'(rsp_data),  32'h66);
    chk("r_addr",  32'(rsp_addr),  32'h0);
    chk("r_err",   32'(rsp_error), 32'h0);
    tick();
    chk("r_idle", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
